control_unit: RTL

//  Instruction-sequencing FSM for the 8-bit processor; the counterpart that drives the datapath's control inputs.

---
 rtl/control_unit_pkg.sv | 73 +++++++
 rtl/control_unit_if.sv | 38 +++
 rtl/control_unit_decode.sv | 36 +++
 rtl/control_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the 8-bit processor controller: opcodes, FSM states,
// instruction classes and bus-mux select codes.
package control_unit_pkg;

   localparam int CPU_WORD_W = 8;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_NOT = 4'h4;
   localparam logic [3:0] OP_RD  = 4'h5;
   localparam logic [3:0] OP_WR  = 4'h6;
   localparam logic [3:0] OP_BR  = 4'h7;
   localparam logic [3:0] OP_BRZ = 4'h8;
   localparam logic [3:0] OP_BRV = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] MUX1_R0 = 3'd0;
   localparam logic [2:0] MUX1_R1 = 3'd1;
   localparam logic [2:0] MUX1_R2 = 3'd2;
   localparam logic [2:0] MUX1_R3 = 3'd3;
   localparam logic [2:0] MUX1_PC = 3'd4;

   localparam logic [1:0] MUX2_ALU  = 2'd0;
   localparam logic [1:0] MUX2_BUS1 = 2'd1;
   localparam logic [1:0] MUX2_MEM  = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FET1 = 4'd1,
      S_FET2 = 4'd2,
      S_DEC  = 4'd3,
      S_EX1  = 4'd4,
      S_RD1  = 4'd5,
      S_RD2  = 4'd6,
      S_WR1  = 4'd7,
      S_WR2  = 4'd8,
      S_BR1  = 4'd9,
      S_BR2  = 4'd10,
      S_HALT = 4'd11
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP  = 4'd0,
      CLS_ALU2 = 4'd1,
      CLS_NOT  = 4'd2,
      CLS_RD   = 4'd3,
      CLS_WR   = 4'd4,
      CLS_BR   = 4'd5,
      CLS_BRZ  = 4'd6,
      CLS_BRV  = 4'd7,
      CLS_HLT  = 4'd8,
      CLS_ILL  = 4'd9
   } op_class_t;

   function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
      logic [3:0] vec;
      case (idx)
         2'd0:    vec = 4'b0001;
         2'd1:    vec = 4'b0010;
         2'd2:    vec = 4'b0100;
         2'd3:    vec = 4'b1000;
         default: vec = 4'b0000;
      endcase
      return vec;
   endfunction

   function automatic logic [2:0] mux1_of_reg(input logic [1:0] idx);
      return {1'b0, idx};
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath signal bundle. master = control_unit, slave = datapath.
interface control_unit_if;
   import control_unit_pkg::*;

   logic [CPU_WORD_W-1:0] instruction;
   logic                  zero;
   logic                  over;
   logic                  load_r0;
   logic                  load_r1;
   logic                  load_r2;
   logic                  load_r3;
   logic                  load_pc;
   logic                  inc_pc;
   logic                  load_ir;
   logic                  load_a_reg;
   logic                  load_reg_y;
   logic                  load_reg_z;
   logic [2:0]            s_b_mux1;
   logic [1:0]            s_b_mux2;
   logic                  write;
   logic                  halted;
   logic                  illegal;

   modport master (
      input  instruction, zero, over,
      output load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir,
             load_a_reg, load_reg_y, load_reg_z, s_b_mux1, s_b_mux2,
             write, halted, illegal
   );

   modport slave (
      output instruction, zero, over,
      input  load_r0, load_r1, load_r2, load_r3, load_pc, inc_pc, load_ir,
             load_a_reg, load_reg_y, load_reg_z, s_b_mux1, s_b_mux2,
             write, halted, illegal
   );

endinterface

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier: instruction class, one-hot destination
// load vector and legality of the opcode.
module ctrl_decode
   import control_unit_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic [1:0] dest,
   output op_class_t  op_class,
   output logic [3:0] dest_load,
   output logic       legal
);

   // opcode to class; A..E fall through to the illegal class
   always_comb begin
      op_class = CLS_ILL;
      legal    = 1'b1;
      case (opcode)
         OP_NOP:                 op_class = CLS_NOP;
         OP_ADD, OP_SUB, OP_AND: op_class = CLS_ALU2;
         OP_NOT:                 op_class = CLS_NOT;
         OP_RD:                  op_class = CLS_RD;
         OP_WR:                  op_class = CLS_WR;
         OP_BR:                  op_class = CLS_BR;
         OP_BRZ:                 op_class = CLS_BRZ;
         OP_BRV:                 op_class = CLS_BRV;
         OP_HLT:                 op_class = CLS_HLT;
         default: begin
            op_class = CLS_ILL;
            legal    = 1'b0;
         end
      endcase
   end

   assign dest_load = reg_onehot(dest);

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing FSM: fetch/decode/execute, halts on HLT or an
// undefined opcode. Strobes are decoded from the registered state.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int WORD_W = 8
)(
   input  logic           clk,
   input  logic           rst,
   control_unit_if.master bus
);

   if (WORD_W != CPU_WORD_W) begin : g_width_check
      $error("control_unit supports only an 8-bit word");
   end

   state_t     state_r;
   logic       illegal_r;

   op_class_t  op_class_s;
   logic [3:0] dest_load_s;
   logic       legal_s;
   logic [1:0] src_s;
   logic [1:0] dest_s;

   logic [3:0] load_vec_s;
   logic       load_pc_s;
   logic       inc_pc_s;
   logic       load_ir_s;
   logic       load_a_s;
   logic       load_y_s;
   logic       load_z_s;
   logic       write_s;
   logic       halted_s;
   logic [2:0] mux1_s;
   logic [1:0] mux2_s;

   assign src_s  = bus.instruction[3:2];
   assign dest_s = bus.instruction[1:0];

   ctrl_decode u_decode (
      .opcode    (bus.instruction[7:4]),
      .dest      (dest_s),
      .op_class  (op_class_s),
      .dest_load (dest_load_s),
      .legal     (legal_s)
   );

   // state register and sticky illegal-opcode flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= S_IDLE;
         illegal_r <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: state_r <= S_FET1;
            S_FET1: state_r <= S_FET2;
            S_FET2: state_r <= S_DEC;
            S_DEC: begin
               if (!legal_s) begin
                  illegal_r <= 1'b1;
               end
               case (op_class_s)
                  CLS_NOP:  state_r <= S_FET1;
                  CLS_NOT:  state_r <= S_FET1;
                  CLS_ALU2: state_r <= S_EX1;
                  CLS_RD:   state_r <= S_RD1;
                  CLS_WR:   state_r <= S_WR1;
                  CLS_BR:   state_r <= S_BR1;
                  CLS_BRZ:  state_r <= bus.zero ? S_BR1 : S_FET1;
                  CLS_BRV:  state_r <= bus.over ? S_BR1 : S_FET1;
                  default:  state_r <= S_HALT;
               endcase
            end
            S_EX1:  state_r <= S_FET1;
            S_RD1:  state_r <= S_RD2;
            S_RD2:  state_r <= S_FET1;
            S_WR1:  state_r <= S_WR2;
            S_WR2:  state_r <= S_FET1;
            S_BR1:  state_r <= S_BR2;
            S_BR2:  state_r <= S_FET1;
            S_HALT: state_r <= S_HALT;
            default: state_r <= S_IDLE;
         endcase
      end
   end

   // control strobes and mux selects for the current state
   always_comb begin
      load_vec_s = 4'b0000;
      load_pc_s  = 1'b0;
      inc_pc_s   = 1'b0;
      load_ir_s  = 1'b0;
      load_a_s   = 1'b0;
      load_y_s   = 1'b0;
      load_z_s   = 1'b0;
      write_s    = 1'b0;
      halted_s   = 1'b0;
      mux1_s     = MUX1_R0;
      mux2_s     = MUX2_ALU;
      case (state_r)
         S_IDLE: begin
            halted_s = 1'b0;
         end
         S_FET1: begin
            mux1_s   = MUX1_PC;
            mux2_s   = MUX2_BUS1;
            load_a_s = 1'b1;
            inc_pc_s = 1'b1;
         end
         S_FET2: begin
            mux2_s    = MUX2_MEM;
            load_ir_s = 1'b1;
         end
         S_DEC: begin
            case (op_class_s)
               CLS_ALU2: begin
                  mux1_s   = mux1_of_reg(src_s);
                  mux2_s   = MUX2_BUS1;
                  load_y_s = 1'b1;
               end
               CLS_NOT: begin
                  mux1_s     = mux1_of_reg(src_s);
                  mux2_s     = MUX2_ALU;
                  load_vec_s = dest_load_s;
                  load_z_s   = 1'b1;
               end
               CLS_RD, CLS_WR, CLS_BR: begin
                  mux1_s   = MUX1_PC;
                  mux2_s   = MUX2_BUS1;
                  load_a_s = 1'b1;
                  inc_pc_s = 1'b1;
               end
               CLS_BRZ, CLS_BRV: begin
                  // taken: point a_reg at the operand; untaken: just step over it
                  if ((op_class_s == CLS_BRZ) ? bus.zero : bus.over) begin
                     mux1_s   = MUX1_PC;
                     mux2_s   = MUX2_BUS1;
                     load_a_s = 1'b1;
                     inc_pc_s = 1'b1;
                  end else begin
                     inc_pc_s = 1'b1;
                  end
               end
               default: begin
                  load_a_s = 1'b0;
               end
            endcase
         end
         S_EX1: begin
            mux1_s     = mux1_of_reg(dest_s);
            mux2_s     = MUX2_ALU;
            load_vec_s = dest_load_s;
            load_z_s   = 1'b1;
         end
         S_RD1, S_WR1, S_BR1: begin
            mux2_s   = MUX2_MEM;
            load_a_s = 1'b1;
         end
         S_RD2: begin
            mux2_s     = MUX2_MEM;
            load_vec_s = dest_load_s;
         end
         S_WR2: begin
            mux1_s  = mux1_of_reg(src_s);
            write_s = 1'b1;
         end
         S_BR2: begin
            mux2_s    = MUX2_MEM;
            load_pc_s = 1'b1;
         end
         S_HALT: begin
            halted_s = 1'b1;
         end
         default: begin
            halted_s = 1'b0;
         end
      endcase
   end

   assign bus.load_r0    = load_vec_s[0];
   assign bus.load_r1    = load_vec_s[1];
   assign bus.load_r2    = load_vec_s[2];
   assign bus.load_r3    = load_vec_s[3];
   assign bus.load_pc    = load_pc_s;
   assign bus.inc_pc     = inc_pc_s;
   assign bus.load_ir    = load_ir_s;
   assign bus.load_a_reg = load_a_s;
   assign bus.load_reg_y = load_y_s;
   assign bus.load_reg_z = load_z_s;
   assign bus.s_b_mux1   = mux1_s;
   assign bus.s_b_mux2   = mux2_s;
   assign bus.write      = write_s;
   assign bus.halted     = halted_s;
   assign bus.illegal    = illegal_r;

endmodule
